// File: rtl/mem_port_arbiter_if.sv
// Bundle between the pipeline fetch/load-store ports, the arbiter and the
// single-port memory macro. The arbiter takes the slave view.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();

  // Instruction-fetch port
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;

  // Data (load/store) port
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;

  // Memory macro side
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Pipeline hold
  logic          stall;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  mem_rdata,
    output if_ack, if_rdata,
    output dm_ack, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output stall
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output mem_rdata,
    input  if_ack, if_rdata,
    input  dm_ack, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  stall
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// holding each access for MEM_LAT cycles and acking with a one-cycle pulse.
module mem_port_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int            CW       = $clog2(MEM_LAT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_DM = 2'd1,
    BUSY_IF = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          mem_en_reg, mem_en_next;
  logic          mem_we_reg, mem_we_next;
  logic [AW-1:0] mem_addr_reg, mem_addr_next;
  logic [DW-1:0] mem_wdata_reg, mem_wdata_next;
  logic          if_ack_reg, if_ack_next;
  logic          dm_ack_reg, dm_ack_next;
  logic [DW-1:0] if_rdata_reg, if_rdata_next;
  logic [DW-1:0] dm_rdata_reg, dm_rdata_next;

  logic if_elig;
  logic dm_elig;

  // A requester still holds req during its own ack cycle; masking it there
  // prevents a stale re-grant and makes the ports alternate under load.
  assign if_elig = bus.if_req & ~if_ack_reg;
  assign dm_elig = bus.dm_req & ~dm_ack_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      if_ack_reg    <= 1'b0;
      dm_ack_reg    <= 1'b0;
      if_rdata_reg  <= '0;
      dm_rdata_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      mem_en_reg    <= mem_en_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      if_ack_reg    <= if_ack_next;
      dm_ack_reg    <= dm_ack_next;
      if_rdata_reg  <= if_rdata_next;
      dm_rdata_reg  <= dm_rdata_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    mem_en_next    = mem_en_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    if_ack_next    = 1'b0;
    dm_ack_next    = 1'b0;
    if_rdata_next  = if_rdata_reg;
    dm_rdata_next  = dm_rdata_reg;

    unique case (state_reg)
      IDLE: begin
        if (dm_elig) begin
          mem_en_next    = 1'b1;
          mem_we_next    = bus.dm_we;
          mem_addr_next  = bus.dm_addr;
          mem_wdata_next = bus.dm_wdata;
          cnt_next       = '0;
          state_next     = BUSY_DM;
        end else if (if_elig) begin
          // Fetches never write; the write-data bus keeps its last value.
          mem_en_next   = 1'b1;
          mem_we_next   = 1'b0;
          mem_addr_next = bus.if_addr;
          cnt_next      = '0;
          state_next    = BUSY_IF;
        end
      end

      BUSY_DM, BUSY_IF: begin
        if (cnt_reg == CNT_LAST) begin
          mem_en_next = 1'b0;
          mem_we_next = 1'b0;
          state_next  = IDLE;
          if (state_reg == BUSY_DM) begin
            dm_ack_next = 1'b1;
            if (!mem_we_reg) begin
              dm_rdata_next = bus.mem_rdata;
            end
          end else begin
            if_ack_next   = 1'b1;
            if_rdata_next = bus.mem_rdata;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      default: begin
        state_next  = IDLE;
        mem_en_next = 1'b0;
        mem_we_next = 1'b0;
      end
    endcase
  end

  assign bus.mem_en    = mem_en_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.if_ack    = if_ack_reg;
  assign bus.dm_ack    = dm_ack_reg;
  assign bus.if_rdata  = if_rdata_reg;
  assign bus.dm_rdata  = dm_rdata_reg;

  // Hold the pipeline from request until the ack cycle itself.
  assign bus.stall = (bus.if_req & ~if_ack_reg) | (bus.dm_req & ~dm_ack_reg);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified memory between the instruction-fetch stage (IF port) and the Mem stage load/store path (DM port).
- Sequences each access across a fixed memory latency and returns read data with a one-cycle ack pulse.
- Drives a pipeline stall while any request is outstanding.
- Sits between the pipeline stages and the memory macro.

Parameters:
- MEM_LAT, 2, memory access cycles per transaction (>=1); mem_* held stable for exactly MEM_LAT cycles.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- if_req  in  1  instruction fetch request; held until if_ack.
- if_addr  in  AW  fetch byte address.
- if_ack  out  1  one-cycle pulse: fetch done, if_rdata valid.
- if_rdata  out  DW  fetched instruction, registered.
- dm_req  in  1  data access request; held until dm_ack.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  AW  data byte address.
- dm_wdata  in  DW  store data.
- dm_ack  out  1  one-cycle pulse: data access done.
- dm_rdata  out  DW  load data, registered.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid on last access cycle.
- stall  out  1  pipeline hold, combinational.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, counter 0. All outputs 0: mem_en, mem_we, mem_addr, mem_wdata, if_ack, dm_ack, if_rdata, dm_rdata. Takes effect immediately.
- State machine: IDLE, BUSY_DM, BUSY_IF.
- IDLE arbitration:
  - A port whose ack is high in the current cycle is ineligible that cycle.
  - Eligible dm_req wins over eligible if_req (fixed priority to the older instruction).
  - On grant, at the clock edge: register address, we (0 for IF), wdata; set mem_en=1; counter=0; go BUSY_DM or BUSY_IF.
- BUSY_x:
  - mem_en, mem_we, mem_addr, mem_wdata stay constant; counter increments each cycle.
  - At the edge where counter==MEM_LAT-1:
    - Load: capture mem_rdata into x_rdata. Store: dm_rdata keeps its previous value.
    - Set x_ack=1 for one cycle.
    - Clear mem_en and mem_we; mem_addr and mem_wdata hold their values.
    - Return to IDLE.
- Latency: request seen in cycle t gives mem_en in cycles t+1..t+MEM_LAT and ack in cycle t+MEM_LAT+1.
  - This is the minimum; a losing requester waits for the winner to finish.
- Back-to-back: ineligibility during the ack cycle means that if both ports keep requesting, ownership alternates DM, IF, DM, ... No starvation.
- stall = (if_req & ~if_ack) | (dm_req & ~dm_ack).
- Request dropped mid-access: the access still completes and acks. Requester signal changes mid-access are ignored, because they are latched at grant.
- Addresses pass through unmodified. No alignment check or byte-enable handling.
- Counter width: $clog2(MEM_LAT)+1. Counter clears on every grant.
- Reset mid-access: access aborted, no ack issued, mem_en drops immediately.

Test Plan:
- Reset: drive random inputs, rst_n low mid-cycle -> all outputs 0 immediately, stall follows the inputs only.
- IF read, MEM_LAT=2: if_req in cycle 0, if_addr=0x100, mem_rdata=0xDEADBEEF -> mem_en=1, mem_addr=0x100 in cycles 1-2; if_ack=1 and if_rdata=0xDEADBEEF in cycle 3; stall=1 in cycles 0-2.
- Contention: dm_req (load 0x40) and if_req (0x104) both in cycle 0 -> DM access in cycles 1-2, dm_ack in cycle 3; IF access in cycles 4-5, if_ack in cycle 6; stall=1 in cycles 0-5.
- Store: dm_we=1, dm_addr=0x80, dm_wdata=0x12345678 -> mem_en=mem_we=1 with those values in cycles 1-2; dm_ack in cycle 3; dm_rdata unchanged.
- Continuous both-port requests for 20 cycles -> grants alternate DM/IF; no ack ever coincides with mem_en of the same port's previous access.
- Reset mid-access: rst_n low in cycle 2 of a DM load -> mem_en=0 immediately, no dm_ack. After release, a new if_req is serviced normally. MEM_LAT=1 variant: ack in cycle 2.
